matrix_result_streamer: RTL and testbench
=========================================

// Module: matrix_result_streamer
// PURPOSE
//   Unload side of the 4x4 matrix multiplier. On the multiplier's one-cycle done pulse it captures
//   the full result matrix C into a shadow buffer. It then streams the elements row-major, one word
//   per handshake, over a valid/ready interface. The multiplier can start its next job as soon as
//   the capture has happened, while downstream logic (DMA, UART framer) drains the results at its
//   own rate.
// PARAMETERS
//   DIM    4    matrix dimension (rows = cols); element count NE = DIM*DIM
//   DW     16   element width, matching the multiplier's C elements
//   OVW    8    width of the saturating overrun counter
// PORTS
//   clk          in   1        single clock; all logic is on its rising edge
//   rst_n        in   1        reset, synchronous and active-low
//   res_done     in   1        one-cycle pulse from the multiplier: res_c is valid this cycle
//   res_c        in   NE*DW    flattened C; element C[i][j] sits at bits [(i*DIM+j)*DW +: DW]
//   m_valid      out  1        m_data/m_row/m_col/m_last hold a valid element
//   m_ready      in   1        downstream accepts the element when m_valid && m_ready
//   m_data       out  DW       element value
//   m_row        out  clog2(DIM) row index i of the current element
//   m_col        out  clog2(DIM) column index j of the current element
//   m_last       out  1        high with the final element, C[DIM-1][DIM-1]
//   busy         out  1        high while in STREAM
//   overrun_cnt  out  OVW      count of res_done pulses dropped; saturates at all-ones
// BEHAVIOUR
//   Reset (rst_n low at an edge): state=IDLE; m_valid, busy and m_last are 0; m_data, m_row,
//     m_col, the element index and overrun_cnt are 0. The shadow buffer is not cleared.
//   Reset mid-stream: remaining elements are discarded. m_valid is low after that edge.
//   FSM IDLE:
//     res_done=1 -> copy res_c into the buffer, set index=0, go to STREAM.
//     m_valid rises on the next cycle, so capture-to-first-valid latency is 1 clk.
//   FSM STREAM:
//     m_valid=1 and busy=1. Outputs come from a registered read of buffer[index].
//     On a handshake (m_valid && m_ready), index advances by 1.
//     On a handshake when index == NE-1 (m_last=1), go to IDLE; m_valid is 0 on the next cycle.
//   Backpressure: while m_valid && !m_ready, m_data, m_row, m_col and m_last hold stable. The
//     index does not move.
//   Throughput: one element per clk while m_ready stays high. A full matrix takes exactly NE
//     handshake cycles.
//   Index decode: m_row = index / DIM and m_col = index % DIM. With DIM a power of 2 these are the
//     upper and lower index bits. m_last = (index == NE-1).
//   Simultaneous events:
//     res_done on the same cycle as the final handshake: the new matrix is captured, the block
//       stays in STREAM with index=0, and there is no bubble (m_valid stays 1).
//     res_done in STREAM at any other cycle: the pulse is dropped, the buffer is unchanged, and
//       overrun_cnt increments (it holds at 2^OVW-1).
//   No arithmetic on the data; elements pass through bit-exact.
// STRUCTURE
//   Shared package mm_pkg:
//     constants MM_DIM=4, MM_DW=16, MM_NE
//     typedef mm_elem_t (logic [MM_DW-1:0])
//     state enum {ST_IDLE, ST_STREAM}
//     function mm_flat_idx(i,j) returning i*DIM+j
//   One sub-module:
//     mrs_shadow_buf: NE x DW register file with a parallel load port (load, din_flat) and a
//     registered read port (raddr, dout).
//   FSM, index counter and overrun counter live in the top level.
// TESTING
//   1. Fill C[i][j]=16*i+j, pulse res_done with m_ready=1 -> m_valid on the next clk; 16 beats
//      with data 0x00..0x33 row-major (C[1][0]=0x10), m_last only on beat 16, then m_valid=0.
//   2. Same load, with m_ready toggling 1,0,0,1... at random -> no word skipped or duplicated;
//      m_data is stable through every stall; m_row/m_col match the data.
//   3. Second res_done (C all 0xBEEF) at element 5 of a stream -> the stream still delivers the
//      first matrix intact; overrun_cnt=1. Repeat 300 overruns -> overrun_cnt=255.
//   4. res_done with C=0xA5A5 on the cycle of the last handshake -> m_valid never drops; the next
//      beat is 0xA5A5 at row 0, col 0; overrun_cnt is unchanged.
//   5. rst_n low at beat 7 with m_ready=1 -> m_valid=0 and busy=0 after that edge; a fresh
//      res_done then streams a full 16 beats from index 0.
//   6. Extremes: C=0xFFFF and 0x0000 alternating by element -> bit-exact passthrough; res_done
//      in IDLE with m_ready=0 for 10 cycles -> beat 0 is held for 10 cycles.

Source files
------------

// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared constants, types and helpers for the 4x4 matrix multiplier datapath
package mm_pkg;

    localparam int MM_DIM = 4;
    localparam int MM_DW  = 16;
    localparam int MM_NE  = MM_DIM * MM_DIM;

    typedef logic [MM_DW-1:0] mm_elem_t;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } mm_state_t;

    function automatic int mm_flat_idx(input int i, input int j);
        return i * MM_DIM + j;
    endfunction

endpackage

// File: rtl/mrs_shadow_buf.sv
// rtl/mrs_shadow_buf.sv - NE x DW result register file with parallel load and registered read
module mrs_shadow_buf #(
    parameter int NE = 16,
    parameter int DW = 16,
    parameter int AW = $clog2(NE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [NE*DW-1:0] din_flat,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   dout
);

    logic [DW-1:0] mem     [NE];
    logic [DW-1:0] din_arr [NE];

    for (genvar e = 0; e < NE; e++) begin : g_unpack
        assign din_arr[e] = din_flat[e*DW +: DW];
    end

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int e = 0; e < NE; e++) begin
                mem[e] <= din_arr[e];
            end
        end
    end

    // Read forwards the incoming matrix so the first element is ready one cycle after capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (load) begin
            dout <= din_arr[raddr];
        end else begin
            dout <= mem[raddr];
        end
    end

endmodule

// File: rtl/matrix_result_streamer.sv
// rtl/matrix_result_streamer.sv - captures result matrix C and streams it row-major over valid/ready
module matrix_result_streamer
    import mm_pkg::*;
#(
    parameter int DIM = MM_DIM,
    parameter int DW  = MM_DW,
    parameter int OVW = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    res_done,
    input  logic [DIM*DIM*DW-1:0]   res_c,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DW-1:0]           m_data,
    output logic [$clog2(DIM)-1:0]  m_row,
    output logic [$clog2(DIM)-1:0]  m_col,
    output logic                    m_last,
    output logic                    busy,
    output logic [OVW-1:0]          overrun_cnt
);

    localparam int NE = DIM * DIM;
    localparam int AW = $clog2(NE);
    localparam int RW = $clog2(DIM);

    mm_state_t      state, state_next;
    logic [AW-1:0]  idx, idx_next;
    logic           load;
    logic           ovr_inc;
    logic           hs;
    logic           at_last;

    assign hs      = (state == ST_STREAM) && m_ready;
    assign at_last = (idx == AW'(NE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            overrun_cnt <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (ovr_inc && (overrun_cnt != '1)) begin
                overrun_cnt <= overrun_cnt + OVW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        load       = 1'b0;
        ovr_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (res_done) begin
                    load       = 1'b1;
                    idx_next   = '0;
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (hs && at_last) begin
                    idx_next = '0;
                    // A capture landing on the final beat chains straight into the next matrix.
                    if (res_done) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    if (hs) begin
                        idx_next = idx + AW'(1);
                    end
                    ovr_inc = res_done;
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    mrs_shadow_buf #(
        .NE (NE),
        .DW (DW),
        .AW (AW)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .din_flat (res_c),
        .raddr    (idx_next),
        .dout     (m_data)
    );

    assign m_valid = (state == ST_STREAM);
    assign busy    = m_valid;
    assign m_last  = m_valid && at_last;
    assign m_row   = idx[AW-1:RW];
    assign m_col   = idx[RW-1:0];

endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb/tb_matrix_result_streamer.sv - randomized directed bench for matrix_result_streamer
module tb_matrix_result_streamer;
    import mm_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         res_done;
    logic [255:0] res_c;
    logic         m_valid;
    logic         m_ready;
    logic [15:0]  m_data;
    logic [1:0]   m_row;
    logic [1:0]   m_col;
    logic         m_last;
    logic         busy;
    logic [7:0]   overrun_cnt;

    int errors = 0;
    int checks = 0;
    logic [15:0] mat [16];

    matrix_result_streamer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .res_done    (res_done),
        .res_c       (res_c),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_row       (m_row),
        .m_col       (m_col),
        .m_last      (m_last),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_c();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                res_c[mm_flat_idx(i, j)*16 +: 16] = mat[mm_flat_idx(i, j)];
    endtask

    task automatic load();
        drive_c();
        res_done = 1'b1;
        step();
        res_done = 1'b0;
    endtask

    // Consumes nbeats elements, comparing each against mat[] in row-major order.
    task automatic run_stream(input bit rnd, input int nbeats, input int inj_at,
                              input logic [15:0] inj_val, input int budget);
        int beat = 0;
        int cyc = 0;
        bit stalled = 0;
        bit injected = 0;
        logic [15:0] prev = '0;
        while (beat < nbeats && cyc < budget) begin
            m_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            res_done = 1'b0;
            if (!injected && beat == inj_at && m_valid) begin
                res_done = 1'b1;
                res_c    = {16{inj_val}};
                injected = 1;
            end
            if (m_valid) begin
                if (stalled) chk("stall_hold", m_data, prev);
                if (m_ready) begin
                    chk("data", m_data, mat[beat]);
                    chk("row", m_row, beat / 4);
                    chk("col", m_col, beat % 4);
                    chk("last", m_last, beat == 15);
                    beat++;
                end
                stalled = !m_ready;
                prev    = m_data;
            end
            step();
            cyc++;
        end
        res_done = 1'b0;
        chk("beat_count", beat, nbeats);
    endtask

    initial begin
        rst_n    = 1'b0;
        res_done = 1'b0;
        res_c    = '0;
        m_ready  = 1'b0;
        step();
        step();
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_row", m_row, 0);
        chk("rst_col", m_col, 0);
        chk("rst_ovr", overrun_cnt, 0);
        rst_n = 1'b1;
        step();

        // Basic row-major stream at full rate
        for (int k = 0; k < 16; k++) mat[k] = 16'(16 * (k / 4) + (k % 4));
        m_ready = 1'b1;
        load();
        chk("t1_first_valid", m_valid, 1);
        chk("t1_busy", busy, 1);
        run_stream(0, 16, -1, 16'h0, 40);
        chk("t1_valid_drop", m_valid, 0);
        chk("t1_busy_drop", busy, 0);

        // Random backpressure
        load();
        run_stream(1, 16, -1, 16'h0, 400);
        chk("t2_valid_drop", m_valid, 0);

        // Overrun mid-stream
        for (int k = 0; k < 16; k++) mat[k] = 16'($urandom);
        load();
        run_stream(0, 16, 5, 16'hBEEF, 40);
        chk("t3_valid_drop", m_valid, 0);
        chk("t3_ovr1", overrun_cnt, 1);

        for (int k = 0; k < 16; k++) mat[k] = 16'($urandom);
        load();
        m_ready = 1'b0;
        res_c = {16{16'hBEEF}};
        for (int p = 0; p < 300; p++) begin
            res_done = 1'b1;
            step();
            res_done = 1'b0;
            step();
            if (p == 99) chk("t3_ovr101", overrun_cnt, 101);
        end
        chk("t3_ovr_sat", overrun_cnt, 255);
        chk("t3_still_valid", m_valid, 1);
        run_stream(0, 16, -1, 16'h0, 40);
        chk("t3b_valid_drop", m_valid, 0);

        // Reset mid-stream
        for (int k = 0; k < 16; k++) mat[k] = 16'($urandom);
        load();
        run_stream(0, 7, -1, 16'h0, 40);
        m_ready = 1'b1;
        rst_n   = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_valid", m_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_data", m_data, 0);
        chk("t5_ovr", overrun_cnt, 0);
        step();
        for (int k = 0; k < 16; k++) mat[k] = 16'($urandom);
        load();
        run_stream(0, 16, -1, 16'h0, 40);
        chk("t5_valid_drop", m_valid, 0);

        // Capture coinciding with final handshake
        for (int k = 0; k < 16; k++) mat[k] = 16'($urandom);
        load();
        run_stream(0, 16, 15, 16'hA5A5, 40);
        chk("t4_no_bubble", m_valid, 1);
        chk("t4_data", m_data, 16'hA5A5);
        chk("t4_row", m_row, 0);
        chk("t4_col", m_col, 0);
        chk("t4_ovr", overrun_cnt, 0);
        for (int k = 0; k < 16; k++) mat[k] = 16'hA5A5;
        run_stream(0, 16, -1, 16'h0, 40);
        chk("t4_valid_drop", m_valid, 0);

        // Extreme patterns and held first beat
        for (int k = 0; k < 16; k++) mat[k] = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
        m_ready = 1'b0;
        load();
        for (int c = 0; c < 10; c++) begin
            chk("t6_hold_valid", m_valid, 1);
            chk("t6_hold_data", m_data, 16'hFFFF);
            step();
        end
        run_stream(0, 16, -1, 16'h0, 40);
        chk("t6_valid_drop", m_valid, 0);
        chk("t6_ovr", overrun_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
